// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   localparam int unsigned ARB_FIXED = 0;
   localparam int unsigned ARB_RR    = 1;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational winner picker: lowest set bit, or first set bit after ptr with wrap.
module sdram_arb_pick #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned IDX_W  = $clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req_m,
   input  logic [IDX_W-1:0]  ptr,
   input  logic              mode,
   output logic [IDX_W-1:0]  win_idx_c,
   output logic              found_c
);

   always_comb begin
      int unsigned idx;
      win_idx_c = '0;
      found_c   = 1'b0;
      idx       = 0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         idx = mode ? ((32'(ptr) + 32'd1 + i) % NUM_CH) : i;
         if (!found_c && req_m[IDX_W'(idx)]) begin
            found_c   = 1'b1;
            win_idx_c = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter_rr.sv
// N-channel SDRAM port arbiter: fixed-priority or round-robin, optional max-hold release.
module sdram_arbiter_rr
   import sdram_pkg::*;
#(
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned IDX_W    = $clog2(NUM_CH),
   parameter int unsigned MODE     = 0,
   parameter int unsigned MAX_HOLD = 0,
   parameter int unsigned HOLD_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] req,
   output logic [NUM_CH-1:0] ack,
   output logic [IDX_W-1:0]  ack_idx,
   output logic              busy,
   output logic              timeout
);

   localparam logic MODE_RR = (MODE == ARB_RR);

   arb_state_e        state_q, state_d;
   logic [NUM_CH-1:0] ack_q, ack_d;
   logic [IDX_W-1:0]  ack_idx_q, ack_idx_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic              excl_vld_q, excl_vld_d;
   logic [IDX_W-1:0]  excl_idx_q, excl_idx_d;

   logic [NUM_CH-1:0] excl_mask_c;
   logic [NUM_CH-1:0] req_m_c;
   logic [IDX_W-1:0]  win_idx_c;
   logic              found_c;

   // A timed-out channel sits out one arbitration unless it is the only requester.
   always_comb begin
      excl_mask_c = excl_vld_q ? (NUM_CH'(1) << excl_idx_q) : '0;
      req_m_c     = ((req & ~excl_mask_c) != '0) ? (req & ~excl_mask_c) : req;
   end

   sdram_arb_pick #(
      .NUM_CH (NUM_CH),
      .IDX_W  (IDX_W)
   ) u_pick (
      .req_m     (req_m_c),
      .ptr       (ptr_q),
      .mode      (MODE_RR),
      .win_idx_c (win_idx_c),
      .found_c   (found_c)
   );

   always_comb begin
      state_d    = state_q;
      ack_d      = ack_q;
      ack_idx_d  = ack_idx_q;
      busy_d     = busy_q;
      timeout_d  = 1'b0;
      hold_d     = hold_q;
      ptr_d      = ptr_q;
      excl_vld_d = excl_vld_q;
      excl_idx_d = excl_idx_q;
      case (state_q)
         ARB_IDLE: begin
            if (found_c) begin
               state_d    = ARB_GRANT;
               ack_d      = NUM_CH'(1) << win_idx_c;
               ack_idx_d  = win_idx_c;
               busy_d     = 1'b1;
               hold_d     = '0;
               ptr_d      = win_idx_c;
               excl_vld_d = 1'b0;
            end
         end
         ARB_GRANT: begin
            // A release on the expiry cycle wins over the forced release.
            if (!req[ack_idx_q]) begin
               state_d = ARB_IDLE;
               ack_d   = '0;
               busy_d  = 1'b0;
            end else if ((MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD - 1))) begin
               state_d    = ARB_IDLE;
               ack_d      = '0;
               busy_d     = 1'b0;
               timeout_d  = 1'b1;
               excl_vld_d = 1'b1;
               excl_idx_d = ack_idx_q;
            end else if (hold_q != '1) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = ARB_IDLE;
            ack_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ARB_IDLE;
         ack_q      <= '0;
         ack_idx_q  <= '0;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
         hold_q     <= '0;
         ptr_q      <= IDX_W'(NUM_CH - 1);
         excl_vld_q <= 1'b0;
         excl_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         ack_idx_q  <= ack_idx_d;
         busy_q     <= busy_d;
         timeout_q  <= timeout_d;
         hold_q     <= hold_d;
         ptr_q      <= ptr_d;
         excl_vld_q <= excl_vld_d;
         excl_idx_q <= excl_idx_d;
      end
   end

   assign ack     = ack_q;
   assign ack_idx = ack_idx_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule
